pipeline_hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage MIPS core. It detects RAW hazards between the instruction in ID and in-flight writers in EX/MEM, and generates PC/IF-ID write enables, IF/ID flush and ID/EX bubble insertion. It also sequences control transfers (beq, bne, j, jal, jr), whose target PC is only resolved in WB: fetch is frozen until the WB redirect arrives. It sits beside the pipeline registers and drives their enable/flush inputs.

---
 rtl/mips_pipeline_pkg.sv | 13 +
 rtl/hazard_compare.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mips_pipeline_pkg.sv
// Shared definitions for the MIPS pipeline sequencing logic: controller states,
// the hard-wired zero register and the default control-transfer wait limit.
package mips_pipeline_pkg;

    typedef enum logic [0:0] {
        RUN       = 1'b0,
        CTRL_WAIT = 1'b1
    } ctrl_state_e;

    localparam logic [4:0] REG_ZERO         = 5'd0;
    localparam int         MAX_WAIT_DEFAULT = 7;

endpackage

// File: rtl/hazard_compare.sv
// Combinational RAW detector: the ID sources against the EX and MEM writers.
// $zero is never a dependency, and WB needs no check because the register file writes first.
module hazard_compare
    import mips_pipeline_pkg::*;
(
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_write_reg,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_write_reg,
    output logic       hazard
);

    function automatic logic src_hazard(input logic uses, input logic [4:0] src,
                                        input logic ex_we, input logic [4:0] ex_wr,
                                        input logic mem_we, input logic [4:0] mem_wr);
        return uses && (src != REG_ZERO) &&
               ((ex_we && (ex_wr == src)) || (mem_we && (mem_wr == src)));
    endfunction

    always_comb begin
        hazard = src_hazard(id_uses_rs, id_rs, ex_reg_write, ex_write_reg,
                            mem_reg_write, mem_write_reg) ||
                 src_hazard(id_uses_rt, id_rt, ex_reg_write, ex_write_reg,
                            mem_reg_write, mem_write_reg);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: RAW stall/bubble insertion and fetch freeze
// while a control transfer waits for its WB-resolved target.
module pipeline_hazard_ctrl
    import mips_pipeline_pkg::*;
#(
    parameter int MAX_WAIT    = MAX_WAIT_DEFAULT,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             ID_Rs,
    input  logic [4:0]             ID_Rt,
    input  logic                   ID_UsesRs,
    input  logic                   ID_UsesRt,
    input  logic                   ID_IsCtrl,
    input  logic                   EX_RegWrite,
    input  logic                   MEM_RegWrite,
    input  logic [4:0]             EX_WriteRegister,
    input  logic [4:0]             MEM_WriteRegister,
    input  logic                   WB_Redirect,
    output logic                   PC_Write,
    output logic                   IF_ID_Write,
    output logic                   IF_ID_Flush,
    output logic                   ID_EX_Bubble,
    output logic                   Timeout,
    output logic [STALL_CNT_W-1:0] StallCycles,
    output logic                   CtrlBusy
);

    localparam int WC_W = $clog2(MAX_WAIT) + 1;

    ctrl_state_e            state_q, state_d;
    logic [WC_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   timeout_q, timeout_d;
    logic                   hazard;
    logic                   pc_w, ifid_w, flush, bubble;

    hazard_compare u_hazard_compare (
        .id_uses_rs    (ID_UsesRs),
        .id_uses_rt    (ID_UsesRt),
        .id_rs         (ID_Rs),
        .id_rt         (ID_Rt),
        .ex_reg_write  (EX_RegWrite),
        .ex_write_reg  (EX_WriteRegister),
        .mem_reg_write (MEM_RegWrite),
        .mem_write_reg (MEM_WriteRegister),
        .hazard        (hazard)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        pc_w       = 1'b0;
        ifid_w     = 1'b0;
        flush      = 1'b0;
        bubble     = 1'b0;
        case (state_q)
            RUN: begin
                // A stalled ID instruction must not start a control sequence yet.
                if (hazard) begin
                    bubble = 1'b1;
                end else if (ID_IsCtrl) begin
                    ifid_w     = 1'b1;
                    flush      = 1'b1;
                    state_d    = CTRL_WAIT;
                    wait_cnt_d = '0;
                end else begin
                    pc_w   = 1'b1;
                    ifid_w = 1'b1;
                end
            end
            CTRL_WAIT: begin
                ifid_w = 1'b1;
                flush  = 1'b1;
                if (WB_Redirect) begin
                    pc_w    = 1'b1;
                    state_d = RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                    if (wait_cnt_q == WC_W'(MAX_WAIT - 1)) begin
                        state_d   = RUN;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase

        stall_d = stall_q;
        if (!pc_w && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            stall_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            timeout_q  <= timeout_d;
        end
    end

    // Pipeline enables are forced low for the whole time reset is held.
    assign PC_Write     = reset & pc_w;
    assign IF_ID_Write  = reset & ifid_w;
    assign IF_ID_Flush  = reset & flush;
    assign ID_EX_Bubble = reset & bubble;
    assign CtrlBusy     = reset & (state_q == CTRL_WAIT);
    assign Timeout      = timeout_q;
    assign StallCycles  = stall_q;

endmodule
